// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int REG_AW          = 3;
    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection.
// Flags an ID-stage source that depends on a load still sitting in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    always_comb begin
        load_use = ex_load && ((id_use1 && (id_rs1 == ex_rd)) ||
                               (id_use2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait, halt, branch flush and load-use stall.
// Optional stall-cycle counter is built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              halt_req,
    input  logic              start,
    output logic              pc_we,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_err,
    output logic [1:0]        state,
    output logic [15:0]       stall_cnt
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       load_use;
    logic       timeout;
    logic [4:0] run_en, en;
    logic [1:0] run_fl, fl;

    hazard_detect u_hazard (
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .id_use1  (id_use1),
        .id_use2  (id_use2),
        .ex_load  (ex_load),
        .ex_rd    (ex_rd),
        .load_use (load_use)
    );

    // Enables/flushes for a cycle that is free to advance: branch beats load-use.
    always_comb begin
        run_en = 5'b11111;
        run_fl = 2'b00;
        if (br_taken) begin
            run_fl = 2'b11;
        end else if (load_use) begin
            run_en = 5'b00111;
            run_fl = 2'b01;
        end
    end

    assign timeout = (wait_cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        en         = '0;
        fl         = '0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (halt_req) begin
                    state_d = HALT;
                end else begin
                    en = run_en;
                    fl = run_fl;
                end
            end
            MEM_WAIT: begin
                // A timeout is treated as an ack so the pipeline cannot wedge.
                if (mem_ack || timeout) begin
                    en        = run_en;
                    fl        = run_fl;
                    state_d   = RUN;
                    mem_err_d = !mem_ack;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!rst) begin
            en = '0;
            fl = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign {ifid_flush, idex_flush} = fl;
    assign mem_err = mem_err_q;
    assign state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a negedge monitor checks them.
// Instance dut uses the default timeout, dut3 uses MEM_TIMEOUT=3 for the timeout scenario.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       rst;
        logic [2:0] id_rs1;
        logic [2:0] id_rs2;
        logic       id_use1;
        logic       id_use2;
        logic       ex_load;
        logic [2:0] ex_rd;
        logic       br_taken;
        logic       mem_req;
        logic       mem_ack;
        logic       halt_req;
        logic       start;
    } in_t;

    typedef struct {
        string       name;
        logic [6:0]  en;
        logic [1:0]  st;
        logic        err;
        logic [15:0] stall;
        bit          sel;
    } exp_t;

    // {pc_we, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] ALL1 = 7'b11111_00;
    localparam logic [6:0] ZERO = 7'b00000_00;
    localparam logic [6:0] BR   = 7'b11111_11;
    localparam logic [6:0] LU   = 7'b00111_01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use1 = 1'b0, id_use2 = 1'b0, ex_load = 1'b0;
    logic       br_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic       halt_req = 1'b0, start = 1'b0;

    logic        a_pc_we, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_fl, a_idex_fl, a_err;
    logic [1:0]  a_state;
    logic [15:0] a_stall;
    logic        b_pc_we, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_fl, b_idex_fl, b_err;
    logic [1:0]  b_state;
    logic [15:0] b_stall;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] stall_model = '0;
    in_t         v;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .ex_load(ex_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .halt_req(halt_req), .start(start),
        .pc_we(a_pc_we), .ifid_en(a_ifid_en), .idex_en(a_idex_en),
        .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
        .ifid_flush(a_ifid_fl), .idex_flush(a_idex_fl),
        .mem_err(a_err), .state(a_state), .stall_cnt(a_stall)
    );

    pipe_ctrl #(.MEM_TIMEOUT(3)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .ex_load(ex_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .halt_req(halt_req), .start(start),
        .pc_we(b_pc_we), .ifid_en(b_ifid_en), .idex_en(b_idex_en),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .ifid_flush(b_ifid_fl), .idex_flush(b_idex_fl),
        .mem_err(b_err), .state(b_state), .stall_cnt(b_stall)
    );

    function automatic in_t idle();
        in_t r;
        r     = '0;
        r.rst = 1'b1;
        return r;
    endfunction

    task automatic applyStimulus(input string name, input in_t in, input logic [6:0] en,
                                 input logic [1:0] st, input logic err, input bit sel);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = in.rst;      id_rs1   = in.id_rs1;   id_rs2  = in.id_rs2;
        id_use1  = in.id_use1;  id_use2  = in.id_use2;  ex_load = in.ex_load;
        ex_rd    = in.ex_rd;    br_taken = in.br_taken; mem_req = in.mem_req;
        mem_ack  = in.mem_ack;  halt_req = in.halt_req; start   = in.start;
        e.name = name;
        e.en   = en;
        e.st   = st;
        e.err  = err;
        e.sel  = sel;
        if (!in.rst) begin
            stall_model = '0;
            e.stall     = '0;
        end else begin
            e.stall = stall_model;
            if (!en[6] && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
        end
`ifndef PIPE_CTRL_PERF_EN
        e.stall = '0;
`endif
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0]  act_en;
        logic [1:0]  act_st;
        logic        act_err;
        act_en  = e.sel ? {b_pc_we, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en, b_ifid_fl, b_idex_fl}
                        : {a_pc_we, a_ifid_en, a_idex_en, a_exmem_en, a_memwb_en, a_ifid_fl, a_idex_fl};
        act_st  = e.sel ? b_state : a_state;
        act_err = e.sel ? b_err : a_err;
        checks++;
        if (act_en !== e.en) begin
            errors++;
            $display("[TB] FAIL %s enables/flushes: got %b expected %b", e.name, act_en, e.en);
        end
        checks++;
        if (act_st !== e.st) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d", e.name, act_st, e.st);
        end
        checks++;
        if (act_err !== e.err) begin
            errors++;
            $display("[TB] FAIL %s mem_err: got %b expected %b", e.name, act_err, e.err);
        end
        if (!e.sel) begin
            checks++;
            if (a_stall !== e.stall) begin
                errors++;
                $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name, a_stall, e.stall);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        v = idle(); v.rst = 1'b0;
        applyStimulus("reset", v, ZERO, 2'd0, 1'b0, 1'b0);
        v.br_taken = 1'b1;
        applyStimulus("reset_gates_branch", v, ZERO, 2'd0, 1'b0, 1'b0);
        v = idle();
        applyStimulus("normal", v, ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.ex_load = 1'b1; v.ex_rd = 3'd3; v.id_use1 = 1'b1; v.id_rs1 = 3'd3;
        applyStimulus("load_use_rs1", v, LU, 2'd0, 1'b0, 1'b0);
        applyStimulus("after_load_use", idle(), ALL1, 2'd0, 1'b0, 1'b0);
        v = idle(); v.ex_load = 1'b1; v.ex_rd = 3'd5; v.id_use2 = 1'b1; v.id_rs2 = 3'd5;
        applyStimulus("load_use_rs2", v, LU, 2'd0, 1'b0, 1'b0);
        v = idle(); v.ex_load = 1'b1; v.ex_rd = 3'd3; v.id_rs1 = 3'd3;
        applyStimulus("no_use_no_stall", v, ALL1, 2'd0, 1'b0, 1'b0);
        v = idle(); v.ex_rd = 3'd3; v.id_use1 = 1'b1; v.id_rs1 = 3'd3;
        applyStimulus("not_load_no_stall", v, ALL1, 2'd0, 1'b0, 1'b0);
        v = idle(); v.ex_load = 1'b1; v.ex_rd = 3'd3; v.id_use1 = 1'b1; v.id_rs1 = 3'd2;
        applyStimulus("reg_mismatch", v, ALL1, 2'd0, 1'b0, 1'b0);
        v = idle(); v.ex_load = 1'b1; v.ex_rd = 3'd3; v.id_use1 = 1'b1; v.id_rs1 = 3'd3; v.br_taken = 1'b1;
        applyStimulus("branch_beats_load_use", v, BR, 2'd0, 1'b0, 1'b0);
        v = idle(); v.br_taken = 1'b1;
        applyStimulus("branch", v, BR, 2'd0, 1'b0, 1'b0);
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1;
        applyStimulus("mem_same_cycle_ack", v, ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.mem_req = 1'b1;
        applyStimulus("mem_wait_enter", v, ZERO, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("mem_wait_hold", v, ZERO, 2'd1, 1'b0, 1'b0);
        v.mem_ack = 1'b1;
        applyStimulus("mem_wait_ack", v, ALL1, 2'd1, 1'b0, 1'b0);
        applyStimulus("mem_wait_done", idle(), ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.mem_req = 1'b1; v.br_taken = 1'b1;
        applyStimulus("mem_br_enter", v, ZERO, 2'd0, 1'b0, 1'b0);
        applyStimulus("mem_br_hold", v, ZERO, 2'd1, 1'b0, 1'b0);
        v.mem_ack = 1'b1;
        applyStimulus("mem_br_release", v, BR, 2'd1, 1'b0, 1'b0);

        v = idle(); v.mem_req = 1'b1; v.halt_req = 1'b1;
        applyStimulus("mem_beats_halt", v, ZERO, 2'd0, 1'b0, 1'b0);
        v = idle(); v.mem_req = 1'b1; v.mem_ack = 1'b1; v.ex_load = 1'b1; v.ex_rd = 3'd6;
        v.id_use2 = 1'b1; v.id_rs2 = 3'd6;
        applyStimulus("mem_ack_load_use", v, LU, 2'd1, 1'b0, 1'b0);
        applyStimulus("mem_lu_done", idle(), ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.halt_req = 1'b1; v.br_taken = 1'b1;
        applyStimulus("halt_enter", v, ZERO, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("halt_hold", idle(), ZERO, 2'd2, 1'b0, 1'b0);
        v = idle(); v.start = 1'b1;
        applyStimulus("halt_start", v, ZERO, 2'd2, 1'b0, 1'b0);
        applyStimulus("halt_resumed", idle(), ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.halt_req = 1'b1;
        applyStimulus("halt2_enter", v, ZERO, 2'd0, 1'b0, 1'b0);
        applyStimulus("halt2_hold", idle(), ZERO, 2'd2, 1'b0, 1'b0);
        v = idle(); v.rst = 1'b0;
        applyStimulus("reset_mid_halt", v, ZERO, 2'd0, 1'b0, 1'b0);
        applyStimulus("after_halt_reset", idle(), ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.mem_req = 1'b1;
        applyStimulus("mw_enter", v, ZERO, 2'd0, 1'b0, 1'b0);
        applyStimulus("mw_hold", v, ZERO, 2'd1, 1'b0, 1'b0);
        v.rst = 1'b0;
        applyStimulus("reset_mid_mem_wait", v, ZERO, 2'd0, 1'b0, 1'b0);
        applyStimulus("after_mw_reset", idle(), ALL1, 2'd0, 1'b0, 1'b0);

        v = idle(); v.mem_req = 1'b1;
        applyStimulus("t3_enter", v, ZERO, 2'd0, 1'b0, 1'b1);
        applyStimulus("t3_wait0", v, ZERO, 2'd1, 1'b0, 1'b1);
        applyStimulus("t3_wait1", v, ZERO, 2'd1, 1'b0, 1'b1);
        applyStimulus("t3_release", v, ALL1, 2'd1, 1'b0, 1'b1);
        applyStimulus("t3_err_pulse", idle(), ALL1, 2'd0, 1'b1, 1'b1);
        applyStimulus("t3_err_clear", idle(), ALL1, 2'd0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
